// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types: machine word, fetch FSM states and the IF/ID
// stage-register payload.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } lc3b_fetch_state;

    typedef struct packed {
        logic     valid;
        lc3b_word ir;
        lc3b_word pc;
    } lc3b_if_id;

    localparam lc3b_word PC_STEP = 16'd2;

    // Sequential PC; wraps modulo 2^16 (16'hFFFE -> 16'h0000).
    function automatic lc3b_word pc_next(input lc3b_word pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/lc3b_fetch_stage_if_id_register.sv
// Flush/stall/load pipeline register between two stages. A flush clears only
// the valid bit; a cycle with neither stall nor load also empties the slot.
module if_id_register
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      stall,
    input  logic      load,
    input  lc3b_if_id d,
    output lc3b_if_id q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (stall) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end else begin
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, runs the imem read/resp
// handshake and feeds the IF/ID register, honouring stalls and redirects.
module lc3b_fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_address,
    output logic        imem_read,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        if_id_valid,
    output logic [15:0] if_id_ir,
    output logic [15:0] if_id_pc
);

    lc3b_fetch_state state, state_d;
    lc3b_word        pc, pc_d;
    lc3b_word        hold_ir, hold_ir_d;
    lc3b_word        pending_pc, pending_pc_d;
    logic            load;
    logic            if_id_free;
    logic            if_id_stall;
    lc3b_if_id       if_id_d, if_id_q;

    assign if_id_free = !if_id_q.valid || !stall_in;

    // An empty slot never needs holding, so a stall only freezes live contents;
    // otherwise a word accepted while the slot is empty would be lost.
    assign if_id_stall = stall_in && if_id_q.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            hold_ir    <= '0;
            pending_pc <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            hold_ir    <= hold_ir_d;
            pending_pc <= pending_pc_d;
        end
    end

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        hold_ir_d     = hold_ir;
        pending_pc_d  = pending_pc;
        load          = 1'b0;
        if_id_d.valid = 1'b1;
        if_id_d.ir    = imem_rdata;
        if_id_d.pc    = pc_next(pc);
        case (state)
            FETCH: begin
                if (imem_resp) begin
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (if_id_free) begin
                        load = 1'b1;
                        pc_d = pc_next(pc);
                    end else begin
                        hold_ir_d = imem_rdata;
                        state_d   = HOLD;
                    end
                end else if (redirect_valid) begin
                    // Address must stay put until the outstanding read returns.
                    pending_pc_d = redirect_pc;
                    state_d      = DISCARD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!stall_in) begin
                    load       = 1'b1;
                    if_id_d.ir = hold_ir;
                    pc_d       = pc_next(pc);
                    state_d    = FETCH;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    pending_pc_d = redirect_pc;
                end
                if (imem_resp) begin
                    pc_d    = redirect_valid ? redirect_pc : pending_pc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        imem_read    = rst_n && (state != HOLD);
        imem_address = pc;
    end

    if_id_register u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .stall (if_id_stall),
        .load  (load),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign if_id_valid = if_id_q.valid;
    assign if_id_ir    = if_id_q.ir;
    assign if_id_pc    = if_id_q.pc;

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Bench for lc3b_fetch_stage: directed scenarios plus a randomized run, checked
// against an architectural in-order instruction-stream model.
module tb_lc3b_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_address;
    logic        imem_read;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        stall_in;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_ir;
    logic [15:0] if_id_pc;

    logic [15:0] mem [0:32767];
    logic [15:0] addr_log [$];
    int          checks = 0;
    int          passes = 0;
    int          deliveries = 0;
    int          lat_cfg = 1;
    bit          inject = 1'b0;
    logic [15:0] exp_pc = RESET_PC;

    always #5 clk = ~clk;

    lc3b_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_address   (imem_address),
        .imem_read      (imem_read),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_ir       (if_id_ir),
        .if_id_pc       (if_id_pc)
    );

    // Memory: answers each read after lat_cfg extra cycles (random 0..3 if negative).
    initial begin : responder
        bit          busy;
        int          cnt;
        logic [15:0] raddr;
        busy = 1'b0;
        cnt = 0;
        raddr = '0;
        imem_resp = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_resp = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                if (inject) begin
                    imem_resp = 1'b1;
                    imem_rdata = 16'hDEAD;
                end
            end else if (imem_read) begin
                if (!busy) begin
                    busy = 1'b1;
                    raddr = imem_address;
                    addr_log.push_back(imem_address);
                    cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
                end else begin
                    checks++;
                    if (imem_address !== raddr)
                        $display("FAIL addr_stable: address=%h required=%h", imem_address, raddr);
                    else
                        passes++;
                end
                if (cnt == 0) begin
                    imem_resp = 1'b1;
                    imem_rdata = mem[raddr[15:1]];
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Architectural model: decode must see mem[a], a+2 for consecutive a,
    // restarting at the target after every redirect.
    initial begin : scoreboard
        logic [15:0] exp_next;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc = RESET_PC;
            end else begin
                if (if_id_valid && !stall_in && !redirect_valid) begin
                    exp_next = exp_pc + 16'd2;
                    checks++;
                    if (if_id_ir !== mem[exp_pc[15:1]] || if_id_pc !== exp_next)
                        $display("FAIL sb_deliver: ir=%h pc=%h required ir=%h pc=%h",
                                 if_id_ir, if_id_pc, mem[exp_pc[15:1]], exp_next);
                    else
                        passes++;
                    deliveries++;
                    exp_pc = exp_next;
                end
                if (redirect_valid) exp_pc = redirect_pc;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic wait_valid_pc(input logic [15:0] p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (if_id_valid && if_id_pc == p) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", if_id_valid);
        else passes++;
        checks++;
        if (if_id_ir !== 16'h0 || if_id_pc !== 16'h0)
            $display("FAIL reset_ifid: ir=%h pc=%h required 0000/0000", if_id_ir, if_id_pc);
        else passes++;
        checks++;
        if (imem_read !== 1'b0) $display("FAIL reset_read: got %b required 0", imem_read);
        else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        addr_log.delete();
        @(negedge clk); #1;
        checks++;
        if (imem_read !== 1'b1 || imem_address !== RESET_PC)
            $display("FAIL reset_first_read: read=%b addr=%h required 1/%h", imem_read, imem_address, RESET_PC);
        else passes++;
    endtask

    task automatic test_free_run();
        bit ok;
        wait_valid_pc(16'h0002, ok);
        checks++;
        if (!ok || if_id_ir !== 16'h1234)
            $display("FAIL free_run_first: ok=%b ir=%h required 1234", ok, if_id_ir);
        else passes++;
    endtask

    task automatic test_stall();
        bit ok;
        @(posedge clk); #1;
        stall_in = 1'b1;
        wait_valid_pc(16'h0004, ok);
        checks++;
        if (!ok || if_id_ir !== 16'h5678)
            $display("FAIL free_run_second: ok=%b ir=%h required 5678", ok, if_id_ir);
        else passes++;
        checks++;
        if (addr_log.size() < 3) $display("FAIL addr_seq: only %0d reads, required 3", addr_log.size());
        else if (addr_log[0] !== 16'h0 || addr_log[1] !== 16'h2 || addr_log[2] !== 16'h4)
            $display("FAIL addr_seq: got %h %h %h required 0000 0002 0004", addr_log[0], addr_log[1], addr_log[2]);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (i > 0) begin
                checks++;
                if (imem_read !== 1'b0 || if_id_valid !== 1'b1 || if_id_ir !== 16'h5678 || if_id_pc !== 16'h0004)
                    $display("FAIL stall_hold: read=%b v=%b ir=%h pc=%h required 0/1/5678/0004",
                             imem_read, if_id_valid, if_id_ir, if_id_pc);
                else passes++;
            end
        end
        @(posedge clk); #1;
        stall_in = 1'b0;
        lat_cfg = 3;
        wait_valid_pc(16'h0006, ok);
        checks++;
        if (!ok || if_id_ir !== mem[2])
            $display("FAIL stall_release: ok=%b ir=%h required %h", ok, if_id_ir, mem[2]);
        else passes++;
        checks++;
        if (imem_read !== 1'b1 || imem_address !== 16'h0006)
            $display("FAIL stall_next_read: read=%b addr=%h required 1/0006", imem_read, imem_address);
        else passes++;
    endtask

    task automatic test_redirect_outstanding();
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk); #1;
        checks++;
        if (imem_address !== 16'h0006) $display("FAIL discard_addr0: addr=%h required 0006", imem_address);
        else passes++;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (imem_read !== 1'b1 || imem_address !== 16'h0006)
                $display("FAIL discard_addr: read=%b addr=%h required 1/0006", imem_read, imem_address);
            else passes++;
        end
        @(negedge clk); #1;
        checks++;
        if (imem_address !== 16'h0100 || if_id_valid !== 1'b0)
            $display("FAIL discard_target: addr=%h v=%b required 0100/0", imem_address, if_id_valid);
        else passes++;
    endtask

    task automatic test_redirect_stall();
        bit ok;
        int idx;
        @(posedge clk); #1;
        stall_in = 1'b1;
        lat_cfg = 1;
        wait_valid_pc(16'h0102, ok);
        checks++;
        if (!ok || if_id_ir !== mem[16'h0080])
            $display("FAIL target_word: ok=%b ir=%h required %h", ok, if_id_ir, mem[16'h0080]);
        else passes++;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0200;
        @(negedge clk); #1;
        checks++;
        if (if_id_valid !== 1'b1) $display("FAIL redir_stall_pre: v=%b required 1", if_id_valid);
        else passes++;
        @(posedge clk); #1;
        idx = addr_log.size();
        redirect_valid = 1'b0;
        stall_in = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (if_id_valid !== 1'b0) $display("FAIL redir_beats_stall: v=%b required 0", if_id_valid);
        else passes++;
        for (int i = 0; i < 10 && addr_log.size() <= idx; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (addr_log.size() <= idx) $display("FAIL redir_stall_read: no read issued, required 0200");
        else if (addr_log[idx] !== 16'h0200)
            $display("FAIL redir_stall_read: addr=%h required 0200", addr_log[idx]);
        else passes++;
    endtask

    task automatic test_wrap();
        bit ok;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_valid_pc(16'h0000, ok);
        checks++;
        if (!ok || if_id_ir !== 16'h0FFF)
            $display("FAIL wrap_word: ok=%b ir=%h required 0FFF", ok, if_id_ir);
        else passes++;
        checks++;
        if (imem_address !== 16'h0000) $display("FAIL wrap_addr: addr=%h required 0000", imem_address);
        else passes++;
    endtask

    task automatic test_reset_midread();
        bit ok;
        bit found;
        logic [15:0] rp;
        rp = RESET_PC;
        lat_cfg = 6;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (imem_read && imem_address == 16'h0040) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) $display("FAIL midread_reach: addr=%h required 0040", imem_address);
        else passes++;
        @(negedge clk); #2;
        rst_n = 1'b0;
        inject = 1'b1;
        #1;
        checks++;
        if (if_id_valid !== 1'b0 || imem_read !== 1'b0)
            $display("FAIL async_reset_ctl: v=%b read=%b required 0/0", if_id_valid, imem_read);
        else passes++;
        checks++;
        if (if_id_ir !== 16'h0 || if_id_pc !== 16'h0 || imem_address !== RESET_PC)
            $display("FAIL async_reset_data: ir=%h pc=%h addr=%h required 0000/0000/%h",
                     if_id_ir, if_id_pc, imem_address, RESET_PC);
        else passes++;
        addr_log.delete();
        repeat (2) begin
            @(negedge clk); #1;
        end
        checks++;
        if (if_id_valid !== 1'b0) $display("FAIL reset_resp_ignored: v=%b required 0", if_id_valid);
        else passes++;
        inject = 1'b0;
        lat_cfg = 1;
        @(negedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_valid_pc(rp + 16'd2, ok);
        checks++;
        if (!ok || if_id_ir !== mem[rp[15:1]])
            $display("FAIL midread_restart: ok=%b ir=%h required %h", ok, if_id_ir, mem[rp[15:1]]);
        else passes++;
        checks++;
        if (addr_log.size() == 0) $display("FAIL midread_first_addr: no read, required %h", rp);
        else if (addr_log[0] !== rp) $display("FAIL midread_first_addr: addr=%h required %h", addr_log[0], rp);
        else passes++;
    endtask

    task automatic test_random();
        int d0;
        lat_cfg = -1;
        d0 = deliveries;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            stall_in = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc = 16'($urandom) & 16'hFFFE;
        end
        @(posedge clk); #1;
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (deliveries - d0 < 50)
            $display("FAIL random_progress: delivered %0d required >= 50", deliveries - d0);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        mem[32767] = 16'h0FFF;
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_outstanding();
        test_redirect_stall();
        test_wrap();
        test_reset_midread();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
